// File: rtl/int_alu_pkg.sv
// Shared ALU opcode encoding and helper functions for the integer ALU array.
// alu_compute works at 64 bits. Callers pass xlen and keep the low XLEN bits.
package int_alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  function automatic logic [63:0] alu_compute(input logic [63:0]         op1,
                                              input logic [63:0]         op2,
                                              input logic [ALU_OP_W-1:0] op,
                                              input logic                word,
                                              input int                  xlen);
    logic [63:0] a_u, b_u, a_s, b_s, res;
    logic [31:0] w_res;
    logic [5:0]  sh;
    logic [4:0]  wsh;
    logic        use_word;
    // On a 32-bit datapath, signed ops see sign-extended operands and logical ops see zero-extended ones.
    if (xlen == 32) begin
      a_u = {32'd0, op1[31:0]};
      b_u = {32'd0, op2[31:0]};
      a_s = {{32{op1[31]}}, op1[31:0]};
      b_s = {{32{op2[31]}}, op2[31:0]};
      sh  = {1'b0, op2[4:0]};
    end else begin
      a_u = op1;
      b_u = op2;
      a_s = op1;
      b_s = op2;
      sh  = op2[5:0];
    end
    wsh      = op2[4:0];
    use_word = word && (xlen == 64) &&
               ((op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLL) ||
                (op == ALU_SRL) || (op == ALU_SRA));
    res   = '0;
    w_res = '0;
    case (op)
      ALU_ADD:  res = a_u + b_u;
      ALU_SUB:  res = a_u - b_u;
      ALU_AND:  res = a_u & b_u;
      ALU_OR:   res = a_u | b_u;
      ALU_XOR:  res = a_u ^ b_u;
      ALU_SLL:  res = a_u << sh;
      ALU_SRL:  res = a_u >> sh;
      ALU_SRA:  res = $signed(a_s) >>> sh;
      ALU_SLT:  res = {63'd0, $signed(a_s) < $signed(b_s)};
      ALU_SLTU: res = {63'd0, a_u < b_u};
      default:  res = '0;
    endcase
    case (op)
      ALU_ADD: w_res = op1[31:0] + op2[31:0];
      ALU_SUB: w_res = op1[31:0] - op2[31:0];
      ALU_SLL: w_res = op1[31:0] << wsh;
      ALU_SRL: w_res = op1[31:0] >> wsh;
      ALU_SRA: w_res = $signed(op1[31:0]) >>> wsh;
      default: w_res = '0;
    endcase
    if (use_word) res = {{32{w_res[31]}}, w_res};
    return res;
  endfunction

  // Distance from the ROB head, modulo 2**rob_w; larger means younger.
  function automatic logic [31:0] rob_age(input logic [31:0] idx,
                                          input logic [31:0] head,
                                          input int          rob_w);
    return (idx - head) & ((32'd1 << rob_w) - 32'd1);
  endfunction

endpackage

// File: rtl/int_alu_lane.sv
// One ALU lane: result is computed at accept, then passes through a STAGES-deep valid/ready pipe.
// Latency is STAGES cycles. in_ready_o depends combinationally on out_ready_i, with no skid buffer.
module int_alu_lane
  import int_alu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 1,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XLEN-1:0]     op1_i,
  input  logic [XLEN-1:0]     op2_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic                word_i,
  input  logic [PREG_W-1:0]   dest_phys_i,
  input  logic [ROB_W-1:0]    rob_idx_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     result_o,
  output logic [PREG_W-1:0]   dest_phys_o,
  output logic [ROB_W-1:0]    rob_idx_o,
  input  logic                flush_i,
  input  logic [ROB_W-1:0]    flush_rob_idx_i,
  input  logic [ROB_W-1:0]    rob_head_i
);

  logic [STAGES-1:0] vld, can_move, adv, kill_q, src_vld, src_kill;
  logic [XLEN-1:0]   res_q   [STAGES];
  logic [XLEN-1:0]   src_res [STAGES];
  logic [PREG_W-1:0] dst_q   [STAGES];
  logic [PREG_W-1:0] src_dst [STAGES];
  logic [ROB_W-1:0]  rob_q   [STAGES];
  logic [ROB_W-1:0]  src_rob [STAGES];
  logic [63:0]       res_full;
  logic [XLEN-1:0]   res_in;
  logic [31:0]       flush_age;
  logic              accept, kill_in, room;

  always_comb begin
    res_full = alu_compute(64'(op1_i), 64'(op2_i), alu_op_i, word_i, XLEN);
  end
  assign res_in = res_full[XLEN-1:0];

  // A stage may move when the output is taken or any later stage holds a bubble.
  always_comb begin
    room     = out_ready_i;
    can_move = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      can_move[k] = room;
      room        = room || !vld[k];
    end
  end

  assign adv        = vld & can_move;
  assign in_ready_o = !vld[0] || can_move[0];
  assign accept     = in_valid_i && in_ready_o;

  assign flush_age = rob_age(32'(flush_rob_idx_i), 32'(rob_head_i), ROB_W);
  assign kill_in   = flush_i && (rob_age(32'(rob_idx_i), 32'(rob_head_i), ROB_W) > flush_age);

  always_comb begin
    kill_q = '0;
    for (int k = 0; k < STAGES; k++) begin
      kill_q[k] = flush_i && (rob_age(32'(rob_q[k]), 32'(rob_head_i), ROB_W) > flush_age);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_vld[k]  = accept;
      assign src_kill[k] = kill_in;
      assign src_res[k]  = res_in;
      assign src_dst[k]  = dest_phys_i;
      assign src_rob[k]  = rob_idx_i;
    end else begin : g_body
      assign src_vld[k]  = adv[k-1];
      assign src_kill[k] = kill_q[k-1];
      assign src_res[k]  = res_q[k-1];
      assign src_dst[k]  = dst_q[k-1];
      assign src_rob[k]  = rob_q[k-1];
    end
  end

  // An entry that moves during a flush is squashed in its new stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        dst_q[k] <= '0;
        rob_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (src_vld[k]) begin
          vld[k]   <= !src_kill[k];
          res_q[k] <= src_res[k];
          dst_q[k] <= src_dst[k];
          rob_q[k] <= src_rob[k];
        end else if (adv[k] || kill_q[k]) begin
          vld[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = vld[STAGES-1];
  assign result_o    = res_q[STAGES-1];
  assign dest_phys_o = dst_q[STAGES-1];
  assign rob_idx_o   = rob_q[STAGES-1];

  a_op_legal: assert property (@(posedge clk) disable iff (rst) accept |-> (alu_op_i <= ALU_SLTU));

endmodule

// File: rtl/int_alu_array.sv
// NUM_PIPES independent ALU lanes with valid/ready handshakes toward writeback and age-based squash.
// Latency is STAGES cycles per lane. A stall in one lane only backpressures that lane's issue port.
module int_alu_array
  import int_alu_pkg::*;
#(
  parameter int NUM_PIPES = 2,
  parameter int XLEN      = 64,
  parameter int STAGES    = 1,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PIPES-1:0]                in_valid_i,
  output logic [NUM_PIPES-1:0]                in_ready_o,
  input  logic [NUM_PIPES-1:0][XLEN-1:0]      op1_i,
  input  logic [NUM_PIPES-1:0][XLEN-1:0]      op2_i,
  input  logic [NUM_PIPES-1:0][ALU_OP_W-1:0]  alu_op_i,
  input  logic [NUM_PIPES-1:0]                word_i,
  input  logic [NUM_PIPES-1:0][PREG_W-1:0]    dest_phys_i,
  input  logic [NUM_PIPES-1:0][ROB_W-1:0]     rob_idx_i,
  output logic [NUM_PIPES-1:0]                out_valid_o,
  input  logic [NUM_PIPES-1:0]                out_ready_i,
  output logic [NUM_PIPES-1:0][XLEN-1:0]      result_o,
  output logic [NUM_PIPES-1:0][PREG_W-1:0]    dest_phys_o,
  output logic [NUM_PIPES-1:0][ROB_W-1:0]     rob_idx_o,
  input  logic                                flush_i,
  input  logic [ROB_W-1:0]                    flush_rob_idx_i,
  input  logic [ROB_W-1:0]                    rob_head_i
);

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_lane
    int_alu_lane #(
      .XLEN   (XLEN),
      .STAGES (STAGES),
      .PREG_W (PREG_W),
      .ROB_W  (ROB_W)
    ) u_lane (
      .clk             (clk),
      .rst             (rst),
      .in_valid_i      (in_valid_i[i]),
      .in_ready_o      (in_ready_o[i]),
      .op1_i           (op1_i[i]),
      .op2_i           (op2_i[i]),
      .alu_op_i        (alu_op_i[i]),
      .word_i          (word_i[i]),
      .dest_phys_i     (dest_phys_i[i]),
      .rob_idx_i       (rob_idx_i[i]),
      .out_valid_o     (out_valid_o[i]),
      .out_ready_i     (out_ready_i[i]),
      .result_o        (result_o[i]),
      .dest_phys_o     (dest_phys_o[i]),
      .rob_idx_o       (rob_idx_o[i]),
      .flush_i         (flush_i),
      .flush_rob_idx_i (flush_rob_idx_i),
      .rob_head_i      (rob_head_i)
    );
  end

endmodule

// File: tb/tb_int_alu_array.sv
// Directed bench: dut_a runs STAGES=1, dut_b runs STAGES=2, and both see the same stimulus.
module tb_int_alu_array;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_valid, out_ready, word;
  logic [1:0][63:0] op1, op2;
  logic [1:0][3:0]  alu_op;
  logic [1:0][6:0]  dest;
  logic [1:0][7:0]  rob;
  logic             flush;
  logic [7:0]       flush_idx, head;

  logic [1:0]       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [1:0][63:0] a_result, b_result;
  logic [1:0][6:0]  a_dest, b_dest;
  logic [1:0][7:0]  a_rob, b_rob;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
  } vec_t;
  vec_t vecs [15];

  always #5 clk = ~clk;

  int_alu_array #(.NUM_PIPES(2), .XLEN(64), .STAGES(1), .PREG_W(7), .ROB_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .op1_i(op1), .op2_i(op2), .alu_op_i(alu_op), .word_i(word),
    .dest_phys_i(dest), .rob_idx_i(rob), .out_valid_o(a_out_valid),
    .out_ready_i(out_ready), .result_o(a_result), .dest_phys_o(a_dest),
    .rob_idx_o(a_rob), .flush_i(flush), .flush_rob_idx_i(flush_idx), .rob_head_i(head)
  );

  int_alu_array #(.NUM_PIPES(2), .XLEN(64), .STAGES(2), .PREG_W(7), .ROB_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .op1_i(op1), .op2_i(op2), .alu_op_i(alu_op), .word_i(word),
    .dest_phys_i(dest), .rob_idx_i(rob), .out_valid_o(b_out_valid),
    .out_ready_i(out_ready), .result_o(b_result), .dest_phys_o(b_dest),
    .rob_idx_o(b_rob), .flush_i(flush), .flush_rob_idx_i(flush_idx), .rob_head_i(head)
  );

  task automatic drive(input int lane, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic w, input logic [6:0] d,
                       input logic [7:0] r);
    in_valid[lane] = 1'b1;
    alu_op[lane]   = op;
    op1[lane]      = a;
    op2[lane]      = b;
    word[lane]     = w;
    dest[lane]     = d;
    rob[lane]      = r;
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 2'b11;
    flush     = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; out_ready = 2'b11; word = '0; op1 = '0; op2 = '0;
    alu_op = '0; dest = '0; rob = '0; flush = 1'b0; flush_idx = '0; head = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (a_out_valid !== 2'b00) begin n_fail++; $display("FAIL reset a_out_valid: got %b want 00", a_out_valid); end
    n_tests++; if (a_result !== '0) begin n_fail++; $display("FAIL reset a_result: got %h want 0", a_result); end
    n_tests++; if (a_in_ready !== 2'b11) begin n_fail++; $display("FAIL reset a_in_ready: got %b want 11", a_in_ready); end
    n_tests++; if (b_out_valid !== 2'b00) begin n_fail++; $display("FAIL reset b_out_valid: got %b want 00", b_out_valid); end
    n_tests++; if (b_in_ready !== 2'b11) begin n_fail++; $display("FAIL reset b_in_ready: got %b want 11", b_in_ready); end
  endtask

  task automatic test_add();
    @(negedge clk);
    drive(0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 7'd5, 8'h10);
    @(negedge clk);
    in_valid = '0;
    n_tests++; if (a_out_valid[0] !== 1'b1 || a_result[0] !== 64'h8000_0000_0000_0000) begin
      n_fail++; $display("FAIL add s1 result: got v=%b %h want v=1 8000000000000000", a_out_valid[0], a_result[0]); end
    n_tests++; if (a_dest[0] !== 7'd5 || a_rob[0] !== 8'h10) begin
      n_fail++; $display("FAIL add s1 tags: got %h/%h want 05/10", a_dest[0], a_rob[0]); end
    n_tests++; if (b_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL add s2 early valid: got %b want 0", b_out_valid[0]); end
    @(negedge clk);
    n_tests++; if (b_out_valid[0] !== 1'b1 || b_result[0] !== 64'h8000_0000_0000_0000 || b_rob[0] !== 8'h10) begin
      n_fail++; $display("FAIL add s2 result: got v=%b %h rob %h want v=1 8000000000000000 rob 10", b_out_valid[0], b_result[0], b_rob[0]); end
    n_tests++; if (a_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL add s1 no dup: got %b want 0", a_out_valid[0]); end
  endtask

  task automatic test_ops();
    vecs[0]  = '{4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};             // ADDW
    vecs[1]  = '{4'd7, 1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000};             // SRAW
    vecs[2]  = '{4'd9, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};                     // SLTU
    vecs[3]  = '{4'd8, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};                     // SLT
    vecs[4]  = '{4'd1, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};                     // SUB
    vecs[5]  = '{4'd5, 1'b0, 64'd1, 64'h43, 64'd8};                                      // SLL, amount masked to 6 bits
    vecs[6]  = '{4'd6, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1};                    // SRL
    vecs[7]  = '{4'd7, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};   // SRA
    vecs[8]  = '{4'd2, 1'b0, 64'hF0F0, 64'hFF00, 64'hF000};                              // AND
    vecs[9]  = '{4'd3, 1'b0, 64'hF0F0, 64'h0F0F, 64'hFFFF};                              // OR
    vecs[10] = '{4'd4, 1'b0, 64'hFFFF, 64'h0F0F, 64'hF0F0};                              // XOR
    vecs[11] = '{4'd6, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000};             // SRLW
    vecs[12] = '{4'd8, 1'b1, 64'h8000_0000, 64'd1, 64'd0};                               // SLT ignores word
    vecs[13] = '{4'd1, 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};                     // SUBW
    vecs[14] = '{4'd5, 1'b1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000};                    // SLLW
    for (int i = 0; i <= 15; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_tests++;
        if (a_out_valid[0] !== 1'b1 || a_rob[0] !== 8'(i - 1) || a_result[0] !== vecs[i-1].e) begin
          n_fail++;
          $display("FAIL op vec%0d: got v=%b rob=%h %h want v=1 rob=%h %h",
                   i - 1, a_out_valid[0], a_rob[0], a_result[0], 8'(i - 1), vecs[i-1].e);
        end
      end
      if (i < 15) drive(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].w, 7'(i), 8'(i));
      else in_valid = '0;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  got_rob [$];
    logic [63:0] got_res [$];
    logic [7:0]  exp_rob [3];
    logic [63:0] exp_res [3];
    exp_rob = '{8'h21, 8'h22, 8'h23};
    exp_res = '{64'd100, 64'd200, 64'd300};
    drain();
    out_ready = 2'b10;
    drive(0, 4'd0, 64'd100, 64'd0, 1'b0, 7'd1, 8'h21);
    drive(1, 4'd1, 64'd50, 64'd8, 1'b0, 7'd9, 8'h31);
    #1;
    n_tests++; if (b_in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp ready1: got %b want 1", b_in_ready[0]); end
    @(negedge clk);
    in_valid[1] = 1'b0;
    drive(0, 4'd0, 64'd200, 64'd0, 1'b0, 7'd2, 8'h22);
    #1;
    n_tests++; if (b_in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp ready2: got %b want 1", b_in_ready[0]); end
    @(negedge clk);
    drive(0, 4'd0, 64'd300, 64'd0, 1'b0, 7'd3, 8'h23);
    #1;
    n_tests++; if (b_in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp ready3: got %b want 0", b_in_ready[0]); end
    n_tests++; if (b_out_valid[1] !== 1'b1 || b_result[1] !== 64'd42 || b_rob[1] !== 8'h31) begin
      n_fail++; $display("FAIL bp lane1: got v=%b %h rob %h want v=1 2a rob 31", b_out_valid[1], b_result[1], b_rob[1]); end
    @(negedge clk);
    n_tests++; if (b_in_ready[0] !== 1'b0 || b_out_valid[0] !== 1'b1 || b_rob[0] !== 8'h21 || b_result[0] !== 64'd100) begin
      n_fail++; $display("FAIL bp hold: got rdy=%b v=%b rob=%h %h want rdy=0 v=1 rob=21 64", b_in_ready[0], b_out_valid[0], b_rob[0], b_result[0]); end
    n_tests++; if (b_out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL bp lane1 dup: got %b want 0", b_out_valid[1]); end
    @(negedge clk);
    out_ready = 2'b11;
    #1;
    n_tests++; if (b_in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp release ready: got %b want 1", b_in_ready[0]); end
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) in_valid[0] = 1'b0;
      if (b_out_valid[0]) begin
        got_rob.push_back(b_rob[0]);
        got_res.push_back(b_result[0]);
      end
    end
    n_tests++; if (got_rob.size() != 3) begin n_fail++; $display("FAIL bp drain count: got %0d want 3", got_rob.size()); end
    for (int i = 0; i < 3 && i < got_rob.size(); i++) begin
      n_tests++;
      if (got_rob[i] !== exp_rob[i] || got_res[i] !== exp_res[i]) begin
        n_fail++; $display("FAIL bp drain order %0d: got rob %h %h want rob %h %h", i, got_rob[i], got_res[i], exp_rob[i], exp_res[i]);
      end
    end
  endtask

  task automatic test_squash();
    logic [7:0] got0 [$];
    logic [7:0] got1 [$];
    drain();
    head = 8'hF0; flush_idx = 8'hF4; out_ready = 2'b00;
    drive(0, 4'd0, 64'd1, 64'd1, 1'b0, 7'd1, 8'hF2);
    drive(1, 4'd0, 64'd1, 64'd1, 1'b0, 7'd2, 8'h01);
    @(negedge clk);
    in_valid[1] = 1'b0;
    drive(0, 4'd0, 64'd2, 64'd2, 1'b0, 7'd3, 8'hF5);
    @(negedge clk);
    in_valid[0] = 1'b0;
    drive(1, 4'd0, 64'd3, 64'd3, 1'b0, 7'd4, 8'hF6);
    flush = 1'b1;
    #1;
    n_tests++; if (b_in_ready[1] !== 1'b1 || b_out_valid[1] !== 1'b1 || b_rob[1] !== 8'h01) begin
      n_fail++; $display("FAIL squash flush cycle: got rdy=%b v=%b rob=%h want rdy=1 v=1 rob=01", b_in_ready[1], b_out_valid[1], b_rob[1]); end
    @(negedge clk);
    flush = 1'b0; in_valid = '0; out_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (b_out_valid[0]) got0.push_back(b_rob[0]);
      if (b_out_valid[1]) got1.push_back(b_rob[1]);
    end
    n_tests++; if (got0.size() != 1) begin n_fail++; $display("FAIL squash lane0 count: got %0d want 1", got0.size()); end
    if (got0.size() > 0) begin
      n_tests++; if (got0[0] !== 8'hF2) begin n_fail++; $display("FAIL squash survivor: got %h want f2", got0[0]); end
    end
    n_tests++; if (got1.size() != 0) begin n_fail++; $display("FAIL squash lane1 count: got %0d want 0", got1.size()); end
    head = '0; flush_idx = '0;
  endtask

  task automatic test_reset_stall();
    drain();
    out_ready = 2'b00;
    drive(0, 4'd0, 64'd7, 64'd7, 1'b0, 7'd7, 8'h40);
    drive(1, 4'd0, 64'd8, 64'd8, 1'b0, 7'd8, 8'h41);
    @(negedge clk);
    drive(0, 4'd0, 64'd9, 64'd9, 1'b0, 7'd9, 8'h42);
    drive(1, 4'd0, 64'd6, 64'd6, 1'b0, 7'd6, 8'h43);
    @(negedge clk);
    in_valid = '0;
    #1;
    n_tests++; if (b_in_ready !== 2'b00) begin n_fail++; $display("FAIL rst stall full: got %b want 00", b_in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (b_out_valid !== 2'b00 || a_out_valid !== 2'b00) begin
      n_fail++; $display("FAIL rst stall valid: got b=%b a=%b want 00/00", b_out_valid, a_out_valid); end
    n_tests++; if (b_result !== '0 || b_dest !== '0 || b_rob !== '0) begin
      n_fail++; $display("FAIL rst stall data: got %h %h %h want 0", b_result, b_dest, b_rob); end
    n_tests++; if (b_in_ready !== 2'b11 || a_in_ready !== 2'b11) begin
      n_fail++; $display("FAIL rst stall ready: got b=%b a=%b want 11/11", b_in_ready, a_in_ready); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_backpressure();
    test_squash();
    test_reset_stall();
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
